mem_pattern_tester: RTL and testbench

MEM_PATTERN_TESTER -- requirements
Module: mem_pattern_tester

---
 rtl/mem_pattern_tester_pkg.sv | 36 +++
 rtl/mem_pattern_tester_if.sv | 24 ++
 rtl/mem_pattern_gen.sv | 41 ++++
 rtl/mem_pattern_tester.sv | 158 +++++++++++++++
 tb/tb_mem_pattern_tester.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pattern_tester_pkg.sv
// Shared types and constants for the memory pattern tester.
package mem_pattern_tester_pkg;

  localparam int DEPTH_DEF  = 7680;
  localparam int ADDR_W_DEF = 13;

  // Right-shift Galois taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_CHECK  = 3'd2,
    S_DRAIN  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_FILL  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_BOTH  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    PAT_ADDR  = 2'd0,
    PAT_NADDR = 2'd1,
    PAT_LFSR  = 2'd2,
    PAT_RSVD  = 2'd3
  } pat_t;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/mem_pattern_tester_if.sv
// Single-port RAM bus between the pattern tester (master) and the RAM (slave).
interface mem_pattern_tester_if #(
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic [31:0]       mem_readdata;

  modport master (
    output mem_address, mem_byteenable, mem_chipselect, mem_write,
           mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport slave (
    input  mem_address, mem_byteenable, mem_chipselect, mem_write,
           mem_writedata, mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/mem_pattern_gen.sv
// Pattern word generator: address, inverted address, or a reloadable Galois LFSR.
module mem_pattern_gen
  import mem_pattern_tester_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              advance,
  input  logic [1:0]        pat_sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       seed,
  output logic [31:0]       data
);
  logic [31:0] lfsr;
  pat_t        pat;

  assign pat = pat_t'(pat_sel);

  // A zero seed would lock the LFSR at zero, so it is replaced by 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= 32'd1;
    end else if (load) begin
      lfsr <= (seed == 32'd0) ? 32'd1 : seed;
    end else if (advance) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  always_comb begin
    data = 32'(addr);
    case (pat)
      PAT_NADDR: data = ~32'(addr);
      PAT_LFSR:  data = lfsr;
      default:   data = 32'(addr);
    endcase
  end

endmodule

// File: rtl/mem_pattern_tester.sv
// Memory pattern tester: writes a selectable pattern to a single-port RAM and
// reads it back, counting mismatches and recording the first failing address.
module mem_pattern_tester
  import mem_pattern_tester_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [1:0]           pat_sel,
  input  logic [31:0]          seed,
  mem_pattern_tester_if.master mem,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_W-1:0]    err_addr,
  output logic [15:0]          err_count
);
  // state    | meaning
  // IDLE     | waiting for start
  // FILL     | one write per cycle, addresses 0..DEPTH-1
  // CHECK    | one read per cycle, compare runs one cycle behind
  // DRAIN    | compare of the final read word
  // FINISH   | done pulse, result valid

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  mode_t             mode_e;
  logic [ADDR_W-1:0] addr, addr_q;
  logic [1:0]        pat_q;
  logic [31:0]       seed_q;
  logic              chk_after;
  logic              cmp_vld;
  logic [31:0]       exp_q;
  logic              gen_load, gen_adv;
  logic [31:0]       gen_seed, gen_data;
  logic              last, mismatch, access;

  assign mode_e   = mode_t'(mode);
  assign last     = (addr == LAST_ADDR);
  assign mismatch = cmp_vld && (mem.mem_readdata != exp_q);
  assign access   = (state == S_FILL) || (state == S_CHECK);
  // The live seed is loaded on the start cycle, the latched one at the start of CHECK
  assign gen_seed = (state == S_IDLE) ? seed : seed_q;

  mem_pattern_gen #(.ADDR_W(ADDR_W)) u_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (gen_load),
    .advance (gen_adv),
    .pat_sel (pat_q),
    .addr    (addr),
    .seed    (gen_seed),
    .data    (gen_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gen_load  = 1'b0;
    gen_adv   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          gen_load  = 1'b1;
          state_nxt = (mode_e == MODE_CHECK) ? S_CHECK : S_FILL;
        end
      end
      S_FILL: begin
        if (last) begin
          gen_load  = chk_after;
          state_nxt = chk_after ? S_CHECK : S_FINISH;
        end else begin
          gen_adv = 1'b1;
        end
      end
      S_CHECK: begin
        gen_adv = 1'b1;
        if (last) state_nxt = S_DRAIN;
      end
      S_DRAIN:  state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr      <= '0;
      addr_q    <= '0;
      pat_q     <= 2'd0;
      seed_q    <= 32'd0;
      chk_after <= 1'b0;
      cmp_vld   <= 1'b0;
      exp_q     <= 32'd0;
      pass      <= 1'b0;
      err_addr  <= '0;
      err_count <= 16'd0;
    end else begin
      cmp_vld <= (state == S_CHECK);
      exp_q   <= gen_data;
      addr_q  <= addr;
      case (state)
        S_IDLE: begin
          if (start) begin
            pat_q     <= pat_sel;
            seed_q    <= seed;
            chk_after <= (mode_e == MODE_BOTH) || (mode_e == MODE_RSVD);
            pass      <= 1'b0;
            err_addr  <= '0;
            err_count <= 16'd0;
            addr      <= '0;
          end
        end
        S_FILL: begin
          if (last) begin
            addr <= '0;
            if (!chk_after) pass <= 1'b1;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        S_CHECK: begin
          if (!last) addr <= addr + 1'b1;
        end
        S_DRAIN: begin
          addr <= '0;
          // The last word's compare lands this cycle, so fold it in directly
          pass <= (err_count == 16'd0) && !mismatch;
        end
        default: addr <= '0;
      endcase
      if (mismatch) begin
        if (err_count == 16'd0)     err_addr  <= addr_q;
        if (err_count != 16'hFFFF)  err_count <= err_count + 16'd1;
      end
    end
  end

  assign busy = access || (state == S_DRAIN);
  assign done = (state == S_FINISH);

  assign mem.mem_chipselect = access;
  assign mem.mem_write      = (state == S_FILL);
  assign mem.mem_address    = access ? addr : '0;
  assign mem.mem_byteenable = access ? 4'hF : 4'h0;
  assign mem.mem_writedata  = (state == S_FILL) ? gen_data : 32'd0;
  assign mem.mem_clken      = 1'b1;

endmodule

// File: tb/tb_mem_pattern_tester.sv
// Directed bench for mem_pattern_tester with a 1-cycle-latency RAM model and a
// run-result scoreboard; a second wide instance exercises err_count saturation.
module tb_mem_pattern_tester;
  localparam int DEPTH   = 7680;
  localparam int ADDR_W  = 13;
  localparam int SDEPTH  = 70000;
  localparam int SADDR_W = 17;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [1:0]        pat_sel = 2'd0;
  logic [31:0]       seed = 32'd0;
  logic              busy, done, pass;
  logic [ADDR_W-1:0] err_addr;
  logic [15:0]       err_count;

  logic               s_reset_n = 1'b0;
  logic               s_start = 1'b0;
  logic               s_busy, s_done, s_pass;
  logic [SADDR_W-1:0] s_err_addr;
  logic [15:0]        s_err_count;

  int total = 0;
  int bad = 0;
  int done_pulses = 0;
  bit sat_finished = 1'b0;

  typedef struct {
    string tag;
    int    cycles;
    bit    pass;
    int    errs;
    int    eaddr;
  } exp_t;
  exp_t sb[$];

  logic [31:0] ram [DEPTH];

  always #5 clk = ~clk;

  mem_pattern_tester_if #(.ADDR_W(ADDR_W))  mif();
  mem_pattern_tester_if #(.ADDR_W(SADDR_W)) sif();

  mem_pattern_tester #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .mode      (mode),
    .pat_sel   (pat_sel),
    .seed      (seed),
    .mem       (mif.master),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_addr  (err_addr),
    .err_count (err_count)
  );

  mem_pattern_tester #(.DEPTH(SDEPTH), .ADDR_W(SADDR_W)) u_sat (
    .clk       (clk),
    .reset_n   (s_reset_n),
    .start     (s_start),
    .mode      (2'd1),
    .pat_sel   (2'd0),
    .seed      (32'd0),
    .mem       (sif.master),
    .busy      (s_busy),
    .done      (s_done),
    .pass      (s_pass),
    .err_addr  (s_err_addr),
    .err_count (s_err_count)
  );

  // RAM model, read data one cycle after the address
  always @(posedge clk) begin
    if (mif.mem_chipselect && mif.mem_clken) begin
      if (mif.mem_write) begin
        if (mif.mem_byteenable == 4'hF) ram[mif.mem_address] <= mif.mem_writedata;
      end else begin
        mif.mem_readdata <= ram[mif.mem_address];
      end
    end
  end

  // Address-pattern words never equal this, so every read of the wide instance mismatches
  assign sif.mem_readdata = 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_pulses++;
    if (reset_n) begin
      chk("byteenable", 32'(mif.mem_byteenable), mif.mem_chipselect ? 32'hF : 32'h0);
      if (!mif.mem_chipselect) chk("idle_address", 32'(mif.mem_address), 32'h0);
    end
  end

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_address"},    32'(mif.mem_address), 32'h0);
    chk({tag, "_byteenable"}, 32'(mif.mem_byteenable), 32'h0);
    chk({tag, "_chipselect"}, 32'(mif.mem_chipselect), 32'h0);
    chk({tag, "_write"},      32'(mif.mem_write), 32'h0);
    chk({tag, "_writedata"},  mif.mem_writedata, 32'h0);
    chk({tag, "_clken"},      32'(mif.mem_clken), 32'h1);
    chk({tag, "_busy"},       32'(busy), 32'h0);
    chk({tag, "_done"},       32'(done), 32'h0);
    chk({tag, "_pass"},       32'(pass), 32'h0);
    chk({tag, "_err_addr"},   32'(err_addr), 32'h0);
    chk({tag, "_err_count"},  32'(err_count), 32'h0);
  endtask

  task automatic run(input string tag, input logic [1:0] m, input logic [1:0] p,
                     input logic [31:0] s, input int cyc, input bit ps, input int errs,
                     input int eaddr, input int restart_at);
    exp_t e;
    exp_t got;
    int   n;
    int   pulses0;
    e.tag = tag; e.cycles = cyc; e.pass = ps; e.errs = errs; e.eaddr = eaddr;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; mode = m; pat_sel = p; seed = s;
    @(negedge clk);
    start = 1'b0;
    pulses0 = done_pulses;
    chk({tag, "_busy_first"}, 32'(busy), 32'h1);
    chk({tag, "_cs_first"}, 32'(mif.mem_chipselect), 32'h1);
    n = 1;
    while (!done && n < cyc + 50) begin
      start = (n == restart_at);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    got = sb.pop_front();
    chk({got.tag, "_cycles"},    32'(n), 32'(got.cycles));
    chk({got.tag, "_busy_done"}, 32'(busy), 32'h0);
    chk({got.tag, "_pass"},      32'(pass), 32'(got.pass));
    chk({got.tag, "_err_count"}, 32'(err_count), 32'(got.errs));
    chk({got.tag, "_err_addr"},  32'(err_addr), 32'(got.eaddr));
    repeat (3) @(negedge clk);
    chk({got.tag, "_done_pulses"}, 32'(done_pulses - pulses0), 32'd1);
    chk({got.tag, "_pass_held"},   32'(pass), 32'(got.pass));
  endtask

  initial begin
    int n;
    s_reset_n = 1'b0;
    repeat (3) @(negedge clk);
    s_reset_n = 1'b1;
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    n = 1;
    while (!s_done && n < SDEPTH + 100) begin
      @(negedge clk);
      n++;
    end
    chk("sat_cycles",    32'(n), 32'(SDEPTH + 2));
    chk("sat_err_count", 32'(s_err_count), 32'hFFFF);
    chk("sat_err_addr",  32'(s_err_addr), 32'h0);
    chk("sat_pass",      32'(s_pass), 32'h0);
    sat_finished = 1'b1;
  end

  initial begin
    logic [31:0] v;
    int pulses0;
    int n;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    reset_n = 1'b1;
    @(negedge clk);
    chk("clken_after_reset", 32'(mif.mem_clken), 32'h1);

    // Address pattern, fill then check, with a stray start at cycle 10
    run("addr_both", 2'd2, 2'd0, 32'd0, 2*DEPTH + 2, 1'b1, 0, 0, 10);
    chk("ram_word0",    ram[0], 32'h0);
    chk("ram_word100",  ram[100], 32'h64);
    chk("ram_word7679", ram[DEPTH-1], 32'd7679);

    // LFSR with seed 0 must equal the seed-1 sequence
    run("lfsr_seed0", 2'd2, 2'd2, 32'd0, 2*DEPTH + 2, 1'b1, 0, 0, 0);
    v = 32'd1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < 3 || i == 100 || i == DEPTH - 1) chk($sformatf("lfsr_word%0d", i), ram[i], v);
      v = lfsr_step(v);
    end
    run("lfsr_seed1_check", 2'd1, 2'd2, 32'd1, DEPTH + 2, 1'b1, 0, 0, 0);

    // Inverted-address fill, corrupt two words, check-only run
    run("inv_fill", 2'd0, 2'd1, 32'd0, DEPTH + 1, 1'b1, 0, 0, 0);
    chk("ram_word5_inv", ram[5], ~32'd5);
    ram[5]       = ram[5] ^ 32'h0000_0100;
    ram[DEPTH-1] = 32'h0;
    run("inv_check", 2'd1, 2'd1, 32'd0, DEPTH + 2, 1'b0, 2, 5, 0);

    // Reset in the middle of a fill
    @(negedge clk);
    start = 1'b1; mode = 2'd0; pat_sel = 2'd0; seed = 32'd0;
    @(negedge clk);
    start = 1'b0;
    pulses0 = done_pulses;
    repeat (2999) @(negedge clk);
    chk("midrun_address", 32'(mif.mem_address), 32'd2999);
    chk("midrun_busy", 32'(busy), 32'h1);
    reset_n = 1'b0;
    #1;
    check_reset("abort");
    repeat (4) @(negedge clk);
    check_reset("abort_hold");
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_access", 32'(mif.mem_chipselect), 32'h0);
    chk("abort_no_done", 32'(done_pulses - pulses0), 32'd0);
    run("post_reset", 2'd2, 2'd0, 32'd0, 2*DEPTH + 2, 1'b1, 0, 0, 0);

    n = 0;
    while (!sat_finished && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk("sat_run_finished", 32'(sat_finished), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
